// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;
  localparam logic [4:0] REG_X0      = 5'd0;

  // Memory beats Writeback; x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       wr_m,
                                          input logic [4:0] rd_w,
                                          input logic       wr_w);
    if (wr_m && (rd_m != REG_X0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (wr_w && (rd_w != REG_X0) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Mul/div occupancy sequencer: holds the op in Execute for MD_LATENCY cycles.
module md_sequencer
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic pc_src,
  output logic md_stall,
  output logic MdBusy,
  output logic MdDoneE
);

  md_state_t        state;
  logic [CNT_W-1:0] count;
  logic             start;

  assign start = (state == IDLE) && md_start && !pc_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            count <= CNT_W'(MD_LATENCY - 2);
          end
        end
        BUSY: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue cycle stalls too, so the op sees MD_LATENCY cycles in Execute.
  assign md_stall = !rst && (start || ((state == BUSY) && (count != '0)));
  assign MdBusy   = !rst && (state == BUSY);
  assign MdDoneE  = !rst && (state == BUSY) && (count == '0);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding, load-use stalls, branch flushes, mul/div freeze.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MdStartE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MdBusy,
  output logic       MdDoneE
);

  logic md_stall;
  logic lw_stall;
  logic front_stall;

  md_sequencer #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) u_md_sequencer (
    .clk     (clk),
    .rst     (rst),
    .md_start(MdStartE),
    .pc_src  (PCSrcE),
    .md_stall(md_stall),
    .MdBusy  (MdBusy),
    .MdDoneE (MdDoneE)
  );

  assign ForwardAE = rst ? FWD_RF : fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = rst ? FWD_RF : fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  // Load-use detection is only meaningful while Execute is not frozen by mul/div.
  assign lw_stall = !rst && !MdBusy && (ResultSrcE == RESULT_LOAD) && (RdE != REG_X0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // A taken branch discards the stalled instruction, so its stall is dropped.
  assign front_stall = md_stall || (lw_stall && !PCSrcE);

  assign StallF = front_stall;
  assign StallD = front_stall;
  assign StallE = md_stall;
  assign FlushD = rst || PCSrcE;
  assign FlushE = rst || PCSrcE || lw_stall;
  assign FlushM = rst || md_stall;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller (latency 4 and latency 2 instances).
module tb_hazard_controller;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MdStartE, md_start2;

  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDoneE;
  logic [1:0] fa2, fb2;
  logic       sf2, sd2, se2, fd2, fe2, fm2, busy2, done2;

  logic [11:0] obs, obs2;
  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;

  hazard_controller #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MdStartE(MdStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MdBusy(MdBusy), .MdDoneE(MdDoneE)
  );

  hazard_controller #(.MD_LATENCY(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MdStartE(md_start2),
    .ForwardAE(fa2), .ForwardBE(fb2), .StallF(sf2), .StallD(sd2),
    .StallE(se2), .FlushD(fd2), .FlushE(fe2), .FlushM(fm2),
    .MdBusy(busy2), .MdDoneE(done2)
  );

  assign obs  = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
                 MdBusy, MdDoneE};
  assign obs2 = {fa2, fb2, sf2, sd2, se2, fd2, fe2, fm2, busy2, done2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {fa, fb, {StallF,StallD,StallE}, {FlushD,FlushE,FlushM}, {MdBusy,MdDoneE}}
  function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [2:0] stl, input logic [2:0] fl,
                                     input logic [1:0] md);
    return {fa, fb, stl, fl, md};
  endfunction

  task automatic chk(input string tag, input logic [11:0] e, input bit second);
    logic [11:0] want;
    logic [11:0] got;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    got  = second ? obs2 : obs;
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", t, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0;
    MdStartE = 0; md_start2 = 0;
  endtask

  initial begin
    clr();
    rst = 1;
    RegWriteM = 1; RdM = 3; Rs1E = 3;
    chk("reset", mk(2'b00, 2'b00, 3'b000, 3'b111, 2'b00), 0);

    rst = 0;
    RegWriteW = 1; RdW = 3;
    chk("fwd_m_prio", mk(2'b10, 2'b00, 3'b000, 3'b000, 2'b00), 0);
    RegWriteM = 0;
    chk("fwd_w", mk(2'b01, 2'b00, 3'b000, 3'b000, 2'b00), 0);
    RegWriteM = 1; RdM = 4; Rs2E = 4;
    chk("fwd_mixed", mk(2'b01, 2'b10, 3'b000, 3'b000, 2'b00), 0);
    RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
    chk("fwd_x0", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b00), 0);

    clr();
    ResultSrcE = 2'b01; RdE = 5; Rs2D = 5;
    chk("lw_stall", mk(2'b00, 2'b00, 3'b110, 3'b010, 2'b00), 0);
    clr();
    chk("lw_bubble", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b00), 0);
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0; Rs2D = 0;
    chk("lw_x0", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b00), 0);
    RdE = 5; Rs1D = 5;
    chk("lw_rs1", mk(2'b00, 2'b00, 3'b110, 3'b010, 2'b00), 0);
    ResultSrcE = 2'b10;
    chk("not_load", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b00), 0);
    ResultSrcE = 2'b01; PCSrcE = 1;
    chk("br_vs_lw", mk(2'b00, 2'b00, 3'b000, 3'b110, 2'b00), 0);

    // Two back-to-back mul/div ops, MdStartE held high throughout.
    clr();
    MdStartE = 1;
    for (int op = 0; op < 2; op++) begin
      chk("md_c0", mk(2'b00, 2'b00, 3'b111, 3'b001, 2'b00), 0);
      ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
      chk("md_c1_nolw", mk(2'b00, 2'b00, 3'b111, 3'b001, 2'b10), 0);
      ResultSrcE = 2'b00; RdE = 0; Rs1D = 0;
      RegWriteM = 1; RdM = 7; Rs1E = 7;
      chk("md_c2_fwd", mk(2'b10, 2'b00, 3'b111, 3'b001, 2'b10), 0);
      RegWriteM = 0; RdM = 0; Rs1E = 0;
      chk("md_c3_done", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b11), 0);
    end
    MdStartE = 0;
    chk("md_idle", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b00), 0);

    MdStartE = 1; PCSrcE = 1;
    chk("br_vs_md", mk(2'b00, 2'b00, 3'b000, 3'b110, 2'b00), 0);
    MdStartE = 0; PCSrcE = 0;
    chk("br_md_stay_idle", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b00), 0);

    MdStartE = 1;
    chk("rst_op_c0", mk(2'b00, 2'b00, 3'b111, 3'b001, 2'b00), 0);
    chk("rst_op_c1", mk(2'b00, 2'b00, 3'b111, 3'b001, 2'b10), 0);
    rst = 1;
    chk("rst_mid_op", mk(2'b00, 2'b00, 3'b000, 3'b111, 2'b00), 0);
    rst = 0; MdStartE = 0;
    chk("rst_after_idle", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b00), 0);
    chk("rst_no_done", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b00), 0);

    clr();
    md_start2 = 1;
    chk("lat2_c0", mk(2'b00, 2'b00, 3'b111, 3'b001, 2'b00), 1);
    chk("lat2_done", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b11), 1);
    md_start2 = 0;
    chk("lat2_idle", mk(2'b00, 2'b00, 3'b000, 3'b000, 2'b00), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
